// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit that stalls the phase-clock divider while busy
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_100M,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            alu_complete
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state, state_next;
  logic [2:0]        f_q;
  logic [2*XLEN-1:0] acc;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [CW-1:0]     count;
  logic              neg_q;    // negate product / quotient in FIX
  logic              neg_r;    // negate remainder in FIX

  logic              signed_a, signed_b, sa, sb, is_div, special;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] step_acc, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Operand decode for the request presented in IDLE: signedness, magnitudes, special divides
  always_comb begin
    signed_a = ~((funct3 == 3'b011) | (funct3 == 3'b101) | (funct3 == 3'b111));
    signed_b = signed_a & (funct3 != 3'b010);
    sa       = signed_a & op_a[XLEN-1];
    sb       = signed_b & op_b[XLEN-1];
    abs_a    = sa ? (~op_a + 1'b1) : op_a;
    abs_b    = sb ? (~op_b + 1'b1) : op_b;
    is_div   = funct3[2];
    // Signed overflow only exists for DIV/REM (funct3[0]==0 within the divide group)
    special  = is_div & ((op_b == '0) |
               (~funct3[0] & (op_a == INT_MIN) & (op_b == {XLEN{1'b1}})));
  end

  // One radix-2 iteration: add-then-shift multiply or restoring divide step
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_trial = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, opnd};
    if (!f_q[2]) begin
      step_acc = {mul_sum, acc[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      step_acc = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      step_acc = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and result selection applied in FIX
  always_comb begin
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    quo_fix  = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix  = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (f_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk_100M) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = special ? FIX : CALC;
      CALC:    if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      f_q          <= '0;
      acc          <= '0;
      opnd         <= '0;
      count        <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      result       <= '0;
      done         <= 1'b0;
      alu_complete <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f_q          <= funct3;
            count        <= '0;
            alu_complete <= 1'b0;
            if (special) begin
              // Preload final {remainder, quotient}; FIX then just selects it
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              acc   <= (op_b == '0) ? {op_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, INT_MIN};
            end else if (is_div) begin
              acc   <= {{XLEN{1'b0}}, abs_a};
              opnd  <= abs_b;
              neg_q <= sa ^ sb;
              neg_r <= sa;
            end else begin
              acc   <= {{XLEN{1'b0}}, abs_b};
              opnd  <= abs_a;
              neg_q <= sa ^ sb;
              neg_r <= 1'b0;
            end
          end
        end
        CALC: begin
          acc   <= step_acc;
          count <= count + 1'b1;
        end
        FIX: begin
          result       <= fix_res;
          done         <= 1'b1;
          alu_complete <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
